// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Elastic pipeline stage register between two datapath stages. It carries a
//   control bundle (all-zero = NOP) and a data bundle, with a valid/ready
//   handshake for stalls, a synchronous flush that inserts a bubble, and an
//   optional skid entry that makes in_ready a pure register output.
//
// Parameters
//   CTRL_W    width of the control bundle
//   DATA_W    width of the data bundle
//   SKID      1: output entry + skid entry, registered in_ready
//             0: output entry only, in_ready depends on out_ready
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   upstream offers a beat
//   in_ready   stage accepts a beat this cycle
//   in_ctrl    upstream control bundle
//   in_data    upstream data bundle
//   flush      synchronous kill of all held and incoming beats
//   out_valid  output entry holds a live beat
//   out_ready  downstream consumes the beat this cycle
//   out_ctrl   control bundle, zero whenever out_valid is low
//   out_data   data bundle, holds its last value when out_valid is low
//   occupancy  number of live entries (0..2)
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned DATA_W = 128,
  parameter bit          SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              o_vld_q, o_vld_d;
  logic [CTRL_W-1:0] o_ctrl_q, o_ctrl_d;
  logic [DATA_W-1:0] o_data_q, o_data_d;
  logic              s_vld_q, s_vld_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;

  logic accept_s;
  logic drain_s;

  // With a skid entry, in_ready is just the inverted skid-valid flop, so no
  // path from out_ready reaches the upstream stage.
  assign in_ready  = SKID ? !s_vld_q : (!o_vld_q || out_ready);
  assign accept_s  = in_valid && in_ready;
  assign drain_s   = o_vld_q && out_ready;

  assign out_valid = o_vld_q;
  assign out_ctrl  = o_vld_q ? o_ctrl_q : {CTRL_W{1'b0}};
  assign out_data  = o_data_q;
  assign occupancy = {1'b0, o_vld_q} + {1'b0, s_vld_q};

  // Next-state selection for the output and skid entries.
  always_comb begin
    o_vld_d  = o_vld_q;
    o_ctrl_d = o_ctrl_q;
    o_data_d = o_data_q;
    s_vld_d  = s_vld_q;
    s_ctrl_d = s_ctrl_q;
    s_data_d = s_data_q;
    if (flush) begin
      // Kill everything; data payloads are left as they are.
      o_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (SKID) begin
      if (drain_s && s_vld_q) begin
        // Parked beat moves forward; a new beat can refill the skid slot.
        o_vld_d  = 1'b1;
        o_ctrl_d = s_ctrl_q;
        o_data_d = s_data_q;
        s_vld_d  = accept_s;
        if (accept_s) begin
          s_ctrl_d = in_ctrl;
          s_data_d = in_data;
        end else begin
          s_ctrl_d = s_ctrl_q;
          s_data_d = s_data_q;
        end
      end else if (drain_s || !o_vld_q) begin
        // Output slot is free (or freeing): a new beat goes straight there.
        o_vld_d = accept_s;
        if (accept_s) begin
          o_ctrl_d = in_ctrl;
          o_data_d = in_data;
        end else begin
          o_ctrl_d = o_ctrl_q;
          o_data_d = o_data_q;
        end
      end else begin
        // Output stalled: an accepted beat parks in the skid entry.
        if (accept_s) begin
          s_vld_d  = 1'b1;
          s_ctrl_d = in_ctrl;
          s_data_d = in_data;
        end else begin
          s_vld_d  = s_vld_q;
        end
      end
    end else begin
      s_vld_d = 1'b0;
      if (accept_s) begin
        o_vld_d  = 1'b1;
        o_ctrl_d = in_ctrl;
        o_data_d = in_data;
      end else if (drain_s) begin
        o_vld_d = 1'b0;
      end else begin
        o_vld_d = o_vld_q;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_vld_q  <= 1'b0;
      o_ctrl_q <= {CTRL_W{1'b0}};
      o_data_q <= {DATA_W{1'b0}};
      s_vld_q  <= 1'b0;
      s_ctrl_q <= {CTRL_W{1'b0}};
      s_data_q <= {DATA_W{1'b0}};
    end else begin
      o_vld_q  <= o_vld_d;
      o_ctrl_q <= o_ctrl_d;
      o_data_q <= o_data_d;
      s_vld_q  <= s_vld_d;
      s_ctrl_q <= s_ctrl_d;
      s_data_q <= s_data_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Drives one SKID=1 instance (a_*) and one SKID=0 instance (b_*). Each is
//   shadowed by a FIFO-queue model: capacity 2 or 1, pop on drain, push on
//   accept, cleared on flush/reset.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [15:0]  c;
    logic [127:0] d;
  } beat_t;

  logic clk = 1'b0;
  logic rst;

  logic         a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
  logic [15:0]  a_in_ctrl, a_out_ctrl;
  logic [127:0] a_in_data, a_out_data;
  logic [1:0]   a_occ;

  logic         b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [15:0]  b_in_ctrl, b_out_ctrl;
  logic [127:0] b_in_data, b_out_data;
  logic [1:0]   b_occ;

  logic [147:0] obs_a, obs_b;
  assign obs_a = {a_out_valid, a_in_ready, a_occ, a_out_ctrl, a_out_data};
  assign obs_b = {b_out_valid, b_in_ready, b_occ, b_out_ctrl, b_out_data};

  beat_t        qa[$];
  beat_t        qb[$];
  logic [127:0] la, lb;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(16), .DATA_W(128), .SKID(1'b1)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
    .flush(a_flush),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
    .occupancy(a_occ)
  );

  pipe_stage_reg #(.CTRL_W(16), .DATA_W(128), .SKID(1'b0)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
    .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
    .occupancy(b_occ)
  );

  // Expected {out_valid, in_ready, occupancy, out_ctrl, out_data} of the SKID=1 stage.
  function automatic logic [147:0] exp_a();
    logic         v;
    logic [15:0]  c;
    logic [127:0] d;
    v = (qa.size() > 0);
    c = v ? qa[0].c : 16'h0000;
    d = v ? qa[0].d : la;
    return {v, (qa.size() < 2), 2'(qa.size()), c, d};
  endfunction

  // Expected outputs of the SKID=0 stage.
  function automatic logic [147:0] exp_b();
    logic         v;
    logic [15:0]  c;
    logic [127:0] d;
    v = (qb.size() > 0);
    c = v ? qb[0].c : 16'h0000;
    d = v ? qb[0].d : lb;
    return {v, (!v || b_out_ready), 2'(qb.size()), c, d};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Advance one clock: update both queue models with the inputs seen at the
  // rising edge, then return at the following falling edge.
  task automatic tick();
    logic  acc_a, acc_b;
    beat_t nb;
    @(posedge clk);
    acc_a = a_in_valid && (qa.size() < 2);
    if (a_flush) begin
      qa.delete();
    end else begin
      if (qa.size() > 0 && a_out_ready) void'(qa.pop_front());
      if (acc_a) begin
        nb.c = a_in_ctrl; nb.d = a_in_data;
        qa.push_back(nb);
      end
    end
    if (qa.size() > 0) la = qa[0].d;
    acc_b = b_in_valid && (qb.size() == 0 || b_out_ready);
    if (b_flush) begin
      qb.delete();
    end else begin
      if (qb.size() > 0 && b_out_ready) void'(qb.pop_front());
      if (acc_b) begin
        nb.c = b_in_ctrl; nb.d = b_in_data;
        qb.push_back(nb);
      end
    end
    if (qb.size() > 0) lb = qb[0].d;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    a_in_valid = 1'b0; a_in_ctrl = 16'h0; a_in_data = 128'h0; a_flush = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_ctrl = 16'h0; b_in_data = 128'h0; b_flush = 1'b0; b_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    qa.delete(); qb.delete(); la = 128'h0; lb = 128'h0;
    @(negedge clk);
    #1;
    n_checks++;
    if (obs_a !== {1'b0, 1'b1, 2'd0, 16'h0, 128'h0})
      $display("FAIL reset_a: got %h expected %h", obs_a, {1'b0, 1'b1, 2'd0, 16'h0, 128'h0});
    else n_pass++;
    n_checks++;
    if (obs_b !== {1'b0, 1'b1, 2'd0, 16'h0, 128'h0})
      $display("FAIL reset_b: got %h expected %h", obs_b, {1'b0, 1'b1, 2'd0, 16'h0, 128'h0});
    else n_pass++;
    rst = 1'b1;
  endtask

  task automatic test_first_beat();
    a_in_valid = 1'b1; a_in_ctrl = 16'h0003; a_in_data = 128'hA5; a_out_ready = 1'b1;
    tick();
    a_in_valid = 1'b0;
    #1;
    n_checks++;
    if ({a_out_valid, a_out_ctrl, a_out_data} !== {1'b1, 16'h0003, 128'hA5})
      $display("FAIL first_beat: got v=%b c=%h d=%h expected v=1 c=0003 d=a5", a_out_valid, a_out_ctrl, a_out_data);
    else n_pass++;
    tick();
    #1;
    n_checks++;
    if ({a_out_valid, a_out_ctrl} !== {1'b0, 16'h0000})
      $display("FAIL first_beat_gone: got v=%b c=%h expected v=0 c=0000", a_out_valid, a_out_ctrl);
    else n_pass++;
    n_checks++;
    if (obs_a !== exp_a()) $display("FAIL first_beat_model: got %h expected %h", obs_a, exp_a());
    else n_pass++;
  endtask

  task automatic test_streaming();
    a_out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      a_in_valid = (i <= 8);
      a_in_ctrl  = 16'(i) | 16'h0100;
      a_in_data  = 128'(i);
      #1;
      n_checks++;
      if (obs_a !== exp_a()) $display("FAIL stream_model: cycle %0d got %h expected %h", i, obs_a, exp_a());
      else n_pass++;
      if (i >= 2 && i <= 9) begin
        n_checks++;
        if (!(a_out_valid === 1'b1 && a_out_data === 128'(i - 1) && a_occ <= 2'd1))
          $display("FAIL stream_seq: got v=%b d=%0h occ=%0d expected v=1 d=%0h occ<=1", a_out_valid, a_out_data, a_occ, i - 1);
        else n_pass++;
      end
      tick();
    end
    a_in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int         idx;
    logic [7:0] got[$];
    idx = 1;
    a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1; a_in_ctrl = 16'h0010; a_in_data = 128'(idx);
      #1;
      if (i == 2) begin
        n_checks++;
        if ({a_occ, a_in_ready} !== {2'd2, 1'b0})
          $display("FAIL bp_full: got occ=%0d rdy=%b expected occ=2 rdy=0", a_occ, a_in_ready);
        else n_pass++;
      end
      n_checks++;
      if (obs_a !== exp_a()) $display("FAIL bp_fill_model: got %h expected %h", obs_a, exp_a());
      else n_pass++;
      if (qa.size() < 2) idx++;
      tick();
    end
    a_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_in_valid = (idx <= 3); a_in_data = 128'(idx);
      #1;
      n_checks++;
      if (obs_a !== exp_a()) $display("FAIL bp_drain_model: got %h expected %h", obs_a, exp_a());
      else n_pass++;
      if (a_out_valid === 1'b1) got.push_back(a_out_data[7:0]);
      if (a_in_valid && qa.size() < 2) idx++;
      tick();
    end
    a_in_valid = 1'b0;
    n_checks++;
    if (got.size() != 3 || got[0] !== 8'd1 || got[1] !== 8'd2 || got[2] !== 8'd3)
      $display("FAIL bp_order: got %0d beats %p expected 1 2 3", got.size(), got);
    else n_pass++;
  endtask

  task automatic test_flush();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_ctrl = 16'h00FF; a_in_data = 128'h11;
    tick();
    a_in_ctrl = 16'h0F0F; a_in_data = 128'h22;
    tick();
    #1;
    n_checks++;
    if ({a_occ, a_out_valid, a_out_ctrl} !== {2'd2, 1'b1, 16'h00FF})
      $display("FAIL flush_pre: got occ=%0d v=%b c=%h expected occ=2 v=1 c=00ff", a_occ, a_out_valid, a_out_ctrl);
    else n_pass++;
    a_flush = 1'b1; a_in_ctrl = 16'h1234; a_in_data = 128'hDEAD;
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    #1;
    n_checks++;
    if ({a_out_valid, a_out_ctrl, a_occ, a_in_ready} !== {1'b0, 16'h0, 2'd0, 1'b1})
      $display("FAIL flush_post: got v=%b c=%h occ=%0d rdy=%b expected v=0 c=0000 occ=0 rdy=1",
               a_out_valid, a_out_ctrl, a_occ, a_in_ready);
    else n_pass++;
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (a_out_valid !== 1'b0 || obs_a !== exp_a())
        $display("FAIL flush_ghost: got %h expected %h", obs_a, exp_a());
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_skid0();
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_ctrl = 16'h0021; b_in_data = 128'h77;
    tick();
    b_in_ctrl = 16'h0042; b_in_data = 128'h88;
    #1;
    n_checks++;
    if ({b_out_valid, b_in_ready} !== {1'b1, 1'b0})
      $display("FAIL skid0_stall: got v=%b rdy=%b expected v=1 rdy=0", b_out_valid, b_in_ready);
    else n_pass++;
    b_out_ready = 1'b1;
    #1;
    n_checks++;
    if (b_in_ready !== 1'b1) $display("FAIL skid0_comb_ready: got %b expected 1", b_in_ready);
    else n_pass++;
    tick();
    b_in_valid = 1'b0;
    #1;
    n_checks++;
    if ({b_out_valid, b_out_ctrl, b_out_data} !== {1'b1, 16'h0042, 128'h88})
      $display("FAIL skid0_replace: got v=%b c=%h d=%h expected v=1 c=0042 d=88", b_out_valid, b_out_ctrl, b_out_data);
    else n_pass++;
    tick();
    b_out_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      a_in_valid  = ($urandom_range(3, 0) != 0);
      a_out_ready = ($urandom_range(2, 0) != 0);
      a_flush     = ($urandom_range(15, 0) == 0);
      a_in_ctrl   = 16'($urandom);
      a_in_data   = rnd128();
      b_in_valid  = ($urandom_range(3, 0) != 0);
      b_out_ready = ($urandom_range(2, 0) != 0);
      b_flush     = ($urandom_range(15, 0) == 0);
      b_in_ctrl   = 16'($urandom);
      b_in_data   = rnd128();
      #1;
      n_checks++;
      if (obs_a !== exp_a()) $display("FAIL rand_a: cycle %0d got %h expected %h", i, obs_a, exp_a());
      else n_pass++;
      n_checks++;
      if (obs_b !== exp_b()) $display("FAIL rand_b: cycle %0d got %h expected %h", i, obs_b, exp_b());
      else n_pass++;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    a_in_valid = 1'b1; a_in_ctrl = 16'h0055; a_in_data = rnd128();
    tick();
    a_in_data = rnd128();
    tick();
    a_in_valid = 1'b0;
    #1;
    n_checks++;
    if (a_occ !== 2'd2) $display("FAIL arst_fill: got occ=%0d expected 2", a_occ);
    else n_pass++;
    #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({a_out_valid, a_out_ctrl, a_out_data, a_occ, a_in_ready} !== {1'b0, 16'h0, 128'h0, 2'd0, 1'b1})
      $display("FAIL arst_immediate: got v=%b c=%h d=%h occ=%0d rdy=%b expected v=0 c=0 d=0 occ=0 rdy=1",
               a_out_valid, a_out_ctrl, a_out_data, a_occ, a_in_ready);
    else n_pass++;
    qa.delete(); qb.delete(); la = 128'h0; lb = 128'h0;
    @(negedge clk);
    rst = 1'b1;
    a_in_valid = 1'b1; a_out_ready = 1'b1; a_in_ctrl = 16'h0009; a_in_data = 128'h99;
    tick();
    a_in_valid = 1'b0;
    #1;
    n_checks++;
    if (obs_a !== exp_a()) $display("FAIL arst_resume: got %h expected %h", obs_a, exp_a());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_first_beat();
    test_streaming();
    test_backpressure();
    test_flush();
    test_skid0();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
